// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types for the UART receive path.
//   parity_t    : parity mode selected by the parity input of uart_rx_ctrl
//   rx_state_t  : receive FSM state; the encoding is visible on state_o
//   maj3        : 3-sample majority vote used by the bit sampler
//   expected_parity : parity bit the transmitter should have sent
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    NO_PARITY    = 3'd0,
    ODD_PARITY   = 3'd1,
    EVEN_PARITY  = 3'd2,
    MARK_PARITY  = 3'd3,
    SPACE_PARITY = 3'd4
  } parity_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_t;

  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // data_xor is the XOR of all received data bits.
  function automatic logic expected_parity(parity_t mode, logic data_xor);
    case (mode)
      ODD_PARITY:  return ~data_xor;
      EVEN_PARITY: return data_xor;
      MARK_PARITY: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_if
// Word-level output channel of the UART receiver.
//   rx_data    : received word, LSB-aligned
//   rx_valid   : word available (held until rx_ready)
//   rx_ready   : consumer accepts the word
//   parity_err, frame_err, brk : status of the word, valid with rx_valid
// master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
  parameter int DATA_MAX = 9
);
  logic [DATA_MAX-1:0] rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic                parity_err;
  logic                frame_err;
  logic                brk;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, brk,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, brk,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Synchronizes the serial line, times each bit period and decides the bit by
// majority vote of three samples around mid-bit.
//   clk, reset_n     : clock, async active-low reset
//   rx_in            : raw serial line (asynchronous)
//   samples_per_bit  : clk cycles per bit
//   active           : receiver is inside a frame; counter held at 0 otherwise
//   restart          : start of a new frame, counter reloads to 0
//   rx_sync          : synchronized line
//   rx_fall          : synchronized high-to-low transition
//   bit_tick         : one-cycle pulse when bit_val holds the decided bit
//   bit_val          : majority of the samples at half-1, half, half+1
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rx_in,
  input  logic [SAMPLE_WIDTH-1:0] samples_per_bit,
  input  logic                    active,
  input  logic                    restart,
  output logic                    rx_sync,
  output logic                    rx_fall,
  output logic                    bit_tick,
  output logic                    bit_val
);

  logic                    sync_q1, sync_q2, sync_prev;
  logic [SAMPLE_WIDTH-1:0] cnt;
  logic [SAMPLE_WIDTH-1:0] half;
  logic                    samp0, samp1;
  logic                    at_s0, at_s1, at_s2, bit_end;

  assign half    = samples_per_bit >> 1;
  assign at_s0   = (cnt == half - SAMPLE_WIDTH'(1));
  assign at_s1   = (cnt == half);
  assign at_s2   = (cnt == half + SAMPLE_WIDTH'(1));
  assign bit_end = (cnt == samples_per_bit - SAMPLE_WIDTH'(1));

  // Synchronizer flops reset to the idle-high line level so that reset
  // release never looks like a start edge on an idle line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1   <= 1'b1;
      sync_q2   <= 1'b1;
      sync_prev <= 1'b1;
      cnt       <= '0;
      samp0     <= 1'b1;
      samp1     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is what turns sync_q1/sync_q2 into a real 2-stage chain.
      sync_q1   <= rx_in;
      sync_q2   <= sync_q1;
      sync_prev <= sync_q2;

      if (restart || !active || bit_end) cnt <= '0;
      else                               cnt <= cnt + SAMPLE_WIDTH'(1);

      if (at_s0) samp0 <= sync_q2;
      if (at_s1) samp1 <= sync_q2;
    end
  end

  assign rx_sync  = sync_q2;
  assign rx_fall  = sync_prev & ~sync_q2;
  // Third sample is taken live on the decision cycle.
  assign bit_tick = active & at_s2;
  assign bit_val  = maj3(samp0, samp1, sync_q2);

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// UART receiver: frame FSM, parity/frame/break checking and a single-entry
// output holding register with valid/ready handshake.
//   clk, reset_n     : clock, async active-low reset
//   enable           : receiver enable, low forces IDLE
//   rx_in            : serial line, idle high
//   samples_per_bit  : clk cycles per bit (>= 8)
//   data_width       : data bits per frame (5..DATA_MAX)
//   parity           : parity mode
//   two_stop         : 1 = two stop bits
//   clear_err        : clears overrun
//   rx_if            : word channel (data, valid/ready, per-word status)
//   overrun          : sticky lost-word flag
//   state_o          : FSM state encoding
// -----------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_MAX     = 9,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    rx_in,
  input  logic [SAMPLE_WIDTH-1:0] samples_per_bit,
  input  logic [3:0]              data_width,
  input  parity_t                 parity,
  input  logic                    two_stop,
  input  logic                    clear_err,
  uart_rx_ctrl_if.master          rx_if,
  output logic                    overrun,
  output logic [2:0]              state_o
);

  rx_state_t           state;
  logic                rx_sync, rx_fall, bit_tick, bit_val;
  logic                start_det;

  logic [3:0]          bit_idx;
  logic [DATA_MAX-1:0] shreg;
  logic                par_acc;    // running XOR of data bits
  logic                par_bad;
  logic                all_zero;   // every bit so far was 0 (break detect)
  logic                frame_bad;  // first of two stop bits was 0
  logic                stop_idx;

  // Completed word, presented to the holding register one cycle later.
  logic                word_done;
  logic [DATA_MAX-1:0] word_data;
  logic                word_perr, word_ferr, word_brk;

  assign start_det = (state == IDLE) && enable && rx_fall;

  uart_rx_sampler #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_sampler (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx_in           (rx_in),
    .samples_per_bit (samples_per_bit),
    .active          (state != IDLE),
    .restart         (start_det),
    .rx_sync         (rx_sync),
    .rx_fall         (rx_fall),
    .bit_tick        (bit_tick),
    .bit_val         (bit_val)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      par_bad   <= 1'b0;
      all_zero  <= 1'b1;
      frame_bad <= 1'b0;
      stop_idx  <= 1'b0;
      word_done <= 1'b0;
      word_data <= '0;
      word_perr <= 1'b0;
      word_ferr <= 1'b0;
      word_brk  <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_det) begin
              state     <= START;
              bit_idx   <= '0;
              shreg     <= '0;
              par_acc   <= 1'b0;
              par_bad   <= 1'b0;
              all_zero  <= 1'b1;
              frame_bad <= 1'b0;
              stop_idx  <= 1'b0;
            end
          end

          START: begin
            // A high majority means the falling edge was noise.
            if (bit_tick) state <= bit_val ? IDLE : DATA;
          end

          DATA: begin
            if (bit_tick) begin
              shreg[bit_idx] <= bit_val;
              par_acc        <= par_acc ^ bit_val;
              all_zero       <= all_zero & ~bit_val;
              if (bit_idx == data_width - 4'd1)
                state <= (parity == NO_PARITY) ? STOP : PARITY;
              else
                bit_idx <= bit_idx + 4'd1;
            end
          end

          PARITY: begin
            if (bit_tick) begin
              par_bad  <= (bit_val != expected_parity(parity, par_acc));
              all_zero <= all_zero & ~bit_val;
              state    <= STOP;
            end
          end

          STOP: begin
            if (bit_tick) begin
              if (!stop_idx && all_zero && !bit_val) begin
                // Line held low through the first stop bit: break.
                word_done <= 1'b1;
                word_data <= shreg;
                word_perr <= par_bad;
                word_ferr <= 1'b1;
                word_brk  <= 1'b1;
                state     <= BREAK_WAIT;
              end else if (!stop_idx && two_stop) begin
                frame_bad <= ~bit_val;
                stop_idx  <= 1'b1;
              end else begin
                word_done <= 1'b1;
                word_data <= shreg;
                word_perr <= par_bad;
                word_ferr <= frame_bad | ~bit_val;
                word_brk  <= 1'b0;
                state     <= IDLE;
              end
            end
          end

          BREAK_WAIT: begin
            if (rx_sync) state <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Single-entry holding register and overrun
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the holding register is reset too, so rx_data reads 0 after
      // reset instead of carrying a word from before it.
      rx_if.rx_data    <= '0;
      rx_if.rx_valid   <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      rx_if.brk        <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      // Accepting the old word on the same edge frees the slot for the new one.
      if (word_done && (!rx_if.rx_valid || rx_if.rx_ready)) begin
        rx_if.rx_data    <= word_data;
        rx_if.parity_err <= word_perr;
        rx_if.frame_err  <= word_ferr;
        rx_if.brk        <= word_brk;
        rx_if.rx_valid   <= 1'b1;
      end else if (rx_if.rx_valid && rx_if.rx_ready) begin
        rx_if.rx_valid <= 1'b0;
      end

      // A lost word wins over clear_err on the same cycle.
      if (word_done && rx_if.rx_valid && !rx_if.rx_ready) overrun <= 1'b1;
      else if (clear_err)                                 overrun <= 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_MAX, default 9: largest supported data width in bits (legal range 5..9).
REQ-002 Parameter SAMPLE_WIDTH, default 16: width of the bit-period divisor.
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  receiver enable; low forces IDLE.
REQ-006 rx_in  input  1  serial line, asynchronous to clk, idle high.
REQ-007 samples_per_bit  input  SAMPLE_WIDTH  clk cycles per bit, minimum legal value 8.
REQ-008 data_width  input  4  data bits per frame, legal range 5..DATA_MAX.
REQ-009 parity  input  parity_t  NO_PARITY, ODD_PARITY, EVEN_PARITY, MARK_PARITY or SPACE_PARITY.
REQ-010 two_stop  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 rx_data  output  DATA_MAX  received word, LSB-aligned, unused upper bits 0.
REQ-012 rx_valid / rx_ready  output / input  1 each  word handshake.
REQ-013 parity_err, frame_err, brk  output  1 each  per-word status, valid with rx_valid.
REQ-014 overrun  output  1  sticky lost-word flag.
REQ-015 clear_err  input  1  synchronous clear of overrun.
REQ-016 state_o  output  3  current state encoding, for debug.

Function
REQ-017 rx_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-018 States SHALL be IDLE, START, DATA, PARITY, STOP and BREAK_WAIT.
REQ-019 IDLE -> START SHALL occur on a synchronized high-to-low transition while enable=1; the bit counter SHALL restart at 0 on that cycle.
REQ-020 Each bit SHALL be decided by 3-sample majority vote at counts half-1, half and half+1 of the bit period, where half = samples_per_bit>>1.
REQ-021 A START majority of 1 SHALL be a false start and return the block to IDLE with no output.
REQ-022 Data bits SHALL be received LSB first; exactly data_width bits SHALL be taken.
REQ-023 PARITY SHALL be skipped when parity=NO_PARITY; otherwise the expected parity bit is: odd or even parity over the data bits, constant 1 for MARK_PARITY, constant 0 for SPACE_PARITY.
REQ-024 STOP SHALL sample one or two stop bits; frame_err SHALL be set if any stop bit is 0.
REQ-025 brk SHALL be set when all data bits, the parity bit (if present) and the first stop bit are all 0; the block SHALL then enter BREAK_WAIT until the synchronized line is 1.
REQ-026 The word SHALL load the output register one cycle after the final stop-bit decision; rx_valid SHALL rise on that same edge.
REQ-027 rx_valid SHALL stay high, with rx_data and the status bits stable, until a cycle with rx_ready=1.
REQ-028 Output transfer SHALL be single-entry: a completed word with rx_valid=1 and rx_ready=0 SHALL be dropped and overrun set.
REQ-029 If the holding register is accepted (rx_ready=1) on the same cycle a new word completes, the new word SHALL load with no overrun.
REQ-030 clear_err and an overrun event on the same cycle SHALL leave overrun=1.
REQ-031 enable falling mid-frame SHALL return the block to IDLE on the next edge, discard the partial word, and leave the holding register untouched.
REQ-032 The bit-period counter SHALL be SAMPLE_WIDTH wide and reload to 0 at the start of each bit; there is no wrap inside a bit.

Reset
REQ-033 On reset_n=0 the block SHALL go to IDLE, synchronizer flops SHALL be 1, and rx_data, rx_valid, parity_err, frame_err, brk and overrun SHALL be 0.
REQ-034 On reset_n=0 state_o SHALL show the IDLE encoding.
REQ-035 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL need a fresh falling edge.

Structure
REQ-036 parity_t, including MARK_PARITY and SPACE_PARITY, and the rx state enum SHALL live in the shared uart_pkg.
REQ-037 Synchronizer, bit-period counter and majority vote SHALL form sub-module uart_rx_sampler, which emits bit_tick and bit_val.

Verification
REQ-038 8N1, samples_per_bit=16, byte 0xA5 -> rx_data=0x0A5, rx_valid rises 1 cycle after the stop decision, no errors.
REQ-039 9-bit word, EVEN_PARITY, data 0x1FF, wrong parity bit -> rx_data=0x1FF, parity_err=1.
REQ-040 Glitch low for 3 cycles with samples_per_bit=16 -> no rx_valid, back in IDLE.
REQ-041 Two frames 0x11, 0x22 with rx_ready=0 -> rx_data=0x11, overrun=1; clear_err -> overrun=0.
REQ-042 Line held low for 2 frame times -> brk=1 and frame_err=1, one word only; next frame after line high is received normally.
REQ-043 reset_n pulse low during DATA -> all outputs 0; a following frame 0x3C is received correctly.
